// File: rtl/in_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : in_port_fifo
//  Purpose  : Buffered input-port feeder for the Mini SRC CPU. A producer
//             pushes words through a valid/ready handshake; the oldest
//             buffered word is presented on in_port_sim and each CPU `in`
//             access (rising edge of in_strobe) retires one word.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH          FIFO entries (power of two, >= 2)
//    WIDTH          data width (matches CPU input port)
//  Ports
//    Clock          in   system clock, rising edge
//    Reset_n        in   asynchronous active-low reset
//    wr_data        in   producer word
//    wr_valid       in   producer offers wr_data
//    wr_ready       out  block accepts a word (== !full)
//    in_strobe      in   CPU input-port enable, may span several cycles
//    in_port_sim    out  word presented to the CPU
//    empty          out  no buffered words
//    full           out  count == DEPTH
//    count          out  buffered word count
//    underflow      out  sticky flag: access made while empty
//    underflow_clr  in   synchronous clear of underflow
//  Build option
//    INPORT_UNDERFLOW_EN  when defined, the sticky underflow flag exists;
//                         otherwise underflow is tied to 0.
// ============================================================================
module in_port_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       in_strobe,
  output logic [WIDTH-1:0]           in_port_sim,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow,
  input  logic                       underflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

  // Storage and state
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             strobe_q, strobe_d;
  logic [WIDTH-1:0] last_word_q, last_word_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_access;
  logic w_pop;

  // Status decoded purely from registers so nothing combinational reaches
  // the outputs from wr_valid or in_strobe.
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_full_count);

  assign w_push   = wr_valid && !w_full;
  // Only the first cycle of a strobe pulse counts as an access.
  assign w_access = in_strobe && !strobe_q;
  assign w_pop    = w_access && !w_empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    strobe_d    = in_strobe;
    last_word_d = last_word_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (w_pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      // Remember the retired word so a drained FIFO keeps presenting it.
      last_word_d = mem_q[rd_ptr_q];
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      strobe_q    <= 1'b0;
      last_word_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      strobe_q    <= strobe_d;
      last_word_q <= last_word_d;
    end
  end

  // Memory array carries no reset: stale entries are never visible because
  // in_port_sim falls back to last_word whenever the FIFO is empty.
  always_ff @(posedge Clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef INPORT_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Set wins over a simultaneous clear.
  always_comb begin
    underflow_d = underflow_q;
    if (underflow_clr) begin
      underflow_d = 1'b0;
    end
    if (w_access && w_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`else
  // Clear input has no effect when the flag is not built.
  logic unused_underflow_clr;
  assign unused_underflow_clr = underflow_clr;
  assign underflow = 1'b0;
`endif

  assign wr_ready    = !w_full;
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = count_q;
  assign in_port_sim = w_empty ? last_word_q : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_in_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_in_port_fifo
//  Purpose  : Self-checking bench for in_port_fifo. A queue-based reference
//             model tracks buffered words, the last delivered word and the
//             sticky underflow flag; directed scenarios are followed by a
//             randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_in_port_fifo;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             in_strobe;
  logic [WIDTH-1:0] in_port_sim;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             underflow;
  logic             underflow_clr;

  in_port_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clock         (Clock),
    .Reset_n       (Reset_n),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .in_strobe     (in_strobe),
    .in_port_sim   (in_port_sim),
    .empty         (empty),
    .full          (full),
    .count         (count),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_last;
  logic        m_prev;
  logic        m_uf;

`ifdef INPORT_UNDERFLOW_EN
  localparam logic c_uf_exp = 1'b1;
`else
  localparam logic c_uf_exp = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_prev = 1'b0;
    m_uf   = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [31:0] d, input logic s, input logic c);
    bit push, acc, pop, uf_set;
    push   = v && (m_q.size() < DEPTH);
    acc    = s && !m_prev;
    pop    = acc && (m_q.size() > 0);
    uf_set = acc && (m_q.size() == 0);
    if (pop)  m_last = m_q.pop_front();
    if (push) m_q.push_back(d);
`ifdef INPORT_UNDERFLOW_EN
    m_uf = uf_set || (m_uf && !c);
`else
    m_uf = 1'b0;
`endif
    m_prev = s;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_port;
    exp_port = (m_q.size() > 0) ? m_q[0] : m_last;
    check("count",       32'(count),       32'(m_q.size()));
    check("empty",       32'(empty),       32'(m_q.size() == 0));
    check("full",        32'(full),        32'(m_q.size() == DEPTH));
    check("wr_ready",    32'(wr_ready),    32'(m_q.size() != DEPTH));
    check("in_port_sim", in_port_sim,      exp_port);
    check("underflow",   32'(underflow),   32'(m_uf));
  endtask

  // One clock: check present outputs, drive inputs, advance the model at
  // the rising edge and return on the following falling edge.
  task automatic cycle(input logic v, input logic [31:0] d, input logic s, input logic c);
    check_outputs();
    wr_valid      = v;
    wr_data       = d;
    in_strobe     = s;
    underflow_clr = c;
    @(posedge Clock);
    model_update(v, d, s, c);
    @(negedge Clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] reads [4];
    reads[0] = 32'h22; reads[1] = 32'h33; reads[2] = 32'h44; reads[3] = 32'h55;

    Reset_n = 1'b0; wr_valid = 1'b0; wr_data = '0; in_strobe = 1'b0; underflow_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_port",  in_port_sim, 32'd0);

    // First push visible one cycle later
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    check("first_word",  in_port_sim, 32'hA5A5_0001);
    check("first_count", 32'(count), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Fill, stall a fifth word, then free a slot
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0);
    cycle(1'b1, 32'h33, 1'b0, 1'b0);
    cycle(1'b1, 32'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    check("stall_full",  32'(full), 32'd1);
    check("stall_ready", 32'(wr_ready), 32'd0);
    check("stall_port",  in_port_sim, 32'h11);
    cycle(1'b1, 32'h55, 1'b1, 1'b0);
    check("after_pop_count", 32'(count), 32'd3);
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    check("accept_55_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("read_order", in_port_sim, reads[i]);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end
    check("drained_port", in_port_sim, 32'h55);

    // Long strobe pulse retires one word only
    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    check("hold_count_before", 32'(count), 32'd2);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("hold_count_after", 32'(count), 32'd1);

    // Drain to 0x44 then access while empty
    cycle(1'b1, 32'h44, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("drain_port",  in_port_sim, 32'h44);
    check("drain_empty", 32'(empty), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("uf_port", in_port_sim, 32'h44);
    check("uf_set",  32'(underflow), 32'(c_uf_exp));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("uf_sticky", 32'(underflow), 32'(c_uf_exp));
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("uf_clr", 32'(underflow), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Simultaneous access and push at count 2, across pointer wrap
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, $urandom, 1'b1, 1'b0);
      check("both_count", 32'(count), 32'd2);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges with 3 words buffered
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd3);
    wr_valid = 1'b0; in_strobe = 1'b0; underflow_clr = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    check("areset_count", 32'(count), 32'd0);
    check("areset_empty", 32'(empty), 32'd1);
    check("areset_port",  in_port_sim, 32'd0);
    model_reset();
    @(negedge Clock);
    Reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 9) < 6), $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
